coverfloat_vector_unpacker: RTL and testbench
=============================================

// Module: coverfloat_vector_unpacker
// PURPOSE
//  Streaming front end for the coverage sampler. It collects a cover vector sent as 32-bit beats,
//  MSB beat first, and buffers whole vectors in a small FIFO.
//  It splits each vector into coverfloat fields and presents one record per out_valid/out_ready
//  transfer; the coverage stage samples on each transfer.
//  The block replaces file-driven unpacking with a synthesizable, back-pressured path.
// PARAMETERS
//  BEAT_W     32  input beat width (bits)
//  FIFO_DEPTH 4   whole-vector FIFO entries; power of 2, >= 2
//  NUM_BEATS  ceil(COVER_VECTOR_WIDTH/BEAT_W)  derived localparam, not overridable
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-high
//  in_valid       in   1        beat valid
//  in_ready       out  1        beat accepted when in_valid && in_ready
//  in_data        in   BEAT_W   beat payload, MSB beat first
//  in_last        in   1        marks final beat of a vector
//  out_valid      out  1        unpacked record available
//  out_ready      in   1        consumer takes record
//  out_op/rm/a/b/c/operand_fmt/result/result_fmt/exception_bits/interm_s/interm_x/interm_m
//                 out  pkg widths  unpacked fields, field order as in the pkg vector_t
//  vector_count   out  32       records delivered; wraps 2^32-1 -> 0
//  frame_err      out  1        sticky; set when in_last arrives at the wrong beat
// BEHAVIOUR
//  - Reset: in_ready=0 for the reset cycle only, then 1; out_valid=0; all field outputs=0;
//    vector_count=0; frame_err=0; beat counter=0; FIFO empty.
//  - Assembler states: IDLE -> COLLECT on the first accepted beat; COLLECT -> PUSH when beat
//    NUM_BEATS-1 is accepted together with in_last.
//  - Beats shift into the MSBs of the assembly register. The last beat is left-aligned; its
//    low pad bits are ignored.
//  - PUSH writes the FIFO in the same cycle as the last beat, then returns to IDLE.
//  - in_ready=0 while the FIFO is full, so no beat is lost.
//  - Framing error: in_last on beat k<NUM_BEATS-1, or no in_last on beat NUM_BEATS-1.
//    Effect: drop the partial vector, set frame_err, and return to IDLE.
//    * Early in_last: the next accepted beat starts a new vector.
//    * Missing in_last: discard beats until a beat with in_last has been accepted.
//  - Output: registered view of the FIFO head.
//    * out_valid rises 1 cycle after the PUSH cycle, so minimum latency is last beat -> out_valid
//      next cycle.
//    * Fields hold stable while out_valid && !out_ready.
//    * vector_count increments on each out transfer.
//  - Simultaneous FIFO push and pop when full: allowed. in_ready stays 0 for that cycle, since
//    it is computed from the registered full flag.
//  - Reset mid-vector or with FIFO data: all contents are discarded with no output.
// CONFIGURATION
//  COVERFLOAT_UNPACK_CHECK_EN defined:
//    - Adds out_field_err (1b, per record, valid with out_valid) = discard bits != 0.
//    - Adds sticky field_err_seen, cleared by reset.
//  Not defined: both ports absent; discard bits are dropped silently.
// STRUCTURE
//  - coverfloat_pkg holds: field width localparams, COVER_VECTOR_WIDTH, the packed vector_t,
//    and the assembler state enum (CF_UNPK_IDLE/COLLECT/DRAIN).
//  - Sub-module coverfloat_vec_fifo: parameterised sync FIFO of vector_t with full/empty flags.
//    The unpacker instantiates it.
// TESTING
//  1. Send 3 back-to-back vectors, out_ready=1 -> 3 records, fields match the packed source,
//     vector_count=3, frame_err=0.
//  2. out_ready=0, send FIFO_DEPTH+1 vectors -> in_ready=0 after 4 stored.
//     Raise out_ready -> all 5 records arrive in order, no loss.
//  3. in_last on beat 2 of a vector, then a good vector -> frame_err=1, exactly 1 record (the
//     good one).
//  4. Assert reset after 5 beats of a vector -> no record; next full vector delivers with
//     vector_count=1.
//  5. Preload vector_count=32'hFFFF_FFFF by force, one transfer -> vector_count=0.
//  6. With COVERFLOAT_UNPACK_CHECK_EN, discard=3'b101 -> out_field_err=1 and field_err_seen=1;
//     discard=0 -> out_field_err=0.

Source files
------------

// File: rtl/coverfloat_pkg.sv
// Shared types for the coverfloat vector unpacker: field widths, the packed
// cover vector layout (MSB first, in the order fields arrive on the stream)
// and the assembler state encoding.
package coverfloat_pkg;

  localparam int unsigned OP_W        = 8;
  localparam int unsigned RM_W        = 8;
  localparam int unsigned OPERAND_W   = 32;
  localparam int unsigned FMT_W       = 8;
  localparam int unsigned RESULT_W    = 32;
  localparam int unsigned EXC_W       = 8;
  localparam int unsigned INTERM_X_W  = 8;
  localparam int unsigned INTERM_M_W  = 32;
  localparam int unsigned DISCARD_W   = 3;

  localparam int unsigned COVER_VECTOR_WIDTH =
    OP_W + RM_W + 3 * OPERAND_W + FMT_W + RESULT_W + FMT_W + EXC_W +
    1 + INTERM_X_W + INTERM_M_W + DISCARD_W;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [RM_W-1:0]       rm;
    logic [OPERAND_W-1:0]  a;
    logic [OPERAND_W-1:0]  b;
    logic [OPERAND_W-1:0]  c;
    logic [FMT_W-1:0]      operand_fmt;
    logic [RESULT_W-1:0]   result;
    logic [FMT_W-1:0]      result_fmt;
    logic [EXC_W-1:0]      exception_bits;
    logic                  interm_s;
    logic [INTERM_X_W-1:0] interm_x;
    logic [INTERM_M_W-1:0] interm_m;
    logic [DISCARD_W-1:0]  discard;
  } vector_t;

  typedef enum logic [1:0] {
    CF_UNPK_IDLE    = 2'd0,
    CF_UNPK_COLLECT = 2'd1,
    CF_UNPK_DRAIN   = 2'd2
  } unpk_state_e;

  // Number of beats needed to carry one cover vector.
  function automatic int unsigned cf_num_beats(input int unsigned beat_w);
    return (COVER_VECTOR_WIDTH + beat_w - 1) / beat_w;
  endfunction

endpackage

// File: rtl/coverfloat_vector_unpacker_if.sv
// Stream-in / record-out bundle of the coverfloat vector unpacker.
// Optional COVERFLOAT_UNPACK_CHECK_EN adds the discard-bit check outputs.
interface coverfloat_vector_unpacker_if #(
  parameter int unsigned BEAT_W = 32
);
  import coverfloat_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [BEAT_W-1:0]     in_data;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [OP_W-1:0]       out_op;
  logic [RM_W-1:0]       out_rm;
  logic [OPERAND_W-1:0]  out_a;
  logic [OPERAND_W-1:0]  out_b;
  logic [OPERAND_W-1:0]  out_c;
  logic [FMT_W-1:0]      out_operand_fmt;
  logic [RESULT_W-1:0]   out_result;
  logic [FMT_W-1:0]      out_result_fmt;
  logic [EXC_W-1:0]      out_exception_bits;
  logic                  out_interm_s;
  logic [INTERM_X_W-1:0] out_interm_x;
  logic [INTERM_M_W-1:0] out_interm_m;

  logic [31:0]           vector_count;
  logic                  frame_err;
`ifdef COVERFLOAT_UNPACK_CHECK_EN
  logic                  out_field_err;
  logic                  field_err_seen;
`endif

  modport master (
`ifdef COVERFLOAT_UNPACK_CHECK_EN
    input  out_field_err, field_err_seen,
`endif
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_op, out_rm, out_a, out_b, out_c,
           out_operand_fmt, out_result, out_result_fmt, out_exception_bits,
           out_interm_s, out_interm_x, out_interm_m, vector_count, frame_err
  );

  modport slave (
`ifdef COVERFLOAT_UNPACK_CHECK_EN
    output out_field_err, field_err_seen,
`endif
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_op, out_rm, out_a, out_b, out_c,
           out_operand_fmt, out_result, out_result_fmt, out_exception_bits,
           out_interm_s, out_interm_x, out_interm_m, vector_count, frame_err
  );

endinterface

// File: rtl/coverfloat_vec_fifo.sv
// Synchronous FIFO of whole cover vectors. Besides full/empty it exposes the
// head and emptiness as they will be after this clock edge, so the consumer
// can keep a registered copy of the head with no extra cycle of latency.
// DEPTH must be a power of two.
module coverfloat_vec_fifo
  import coverfloat_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  vector_t wdata,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output logic    empty_next,
  output vector_t head_next
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  vector_t       mem_q [DEPTH];
  vector_t       mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Pointer/count update; a push into a full FIFO is taken only alongside a pop.
  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Head after this edge, zero when the FIFO will be empty.
  always_comb begin
    head_next = '0;
    if (!empty_d) begin
      head_next = mem_d[rd_ptr_d];
    end
  end

  // Control state with synchronous reset; contents need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign empty_next = empty_d;

endmodule

// File: rtl/coverfloat_vector_unpacker.sv
// Coverfloat vector unpacker: assembles MSB-first beats into cover vectors,
// buffers whole vectors in coverfloat_vec_fifo and presents the FIFO head as
// registered, field-split records on an out_valid/out_ready handshake.
// Build option COVERFLOAT_UNPACK_CHECK_EN adds out_field_err/field_err_seen.
//
//  state           | meaning
//  CF_UNPK_IDLE    | waiting for the first beat of a vector (beat count 0)
//  CF_UNPK_COLLECT | beats 1..NUM_BEATS-1 being gathered
//  CF_UNPK_DRAIN   | vector lacked in_last on its final beat; drop beats up to in_last
module coverfloat_vector_unpacker
  import coverfloat_pkg::*;
#(
  parameter int unsigned BEAT_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                          clk,
  input logic                          reset,
  coverfloat_vector_unpacker_if.slave  bus
);

  localparam int unsigned NUM_BEATS = cf_num_beats(BEAT_W);
  localparam int unsigned FRAME_W   = NUM_BEATS * BEAT_W;
  localparam int unsigned ASM_W     = (NUM_BEATS - 1) * BEAT_W;
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

  unpk_state_e      state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic             frame_err_q, frame_err_d;
  logic [31:0]      vector_count_q, vector_count_d;
  logic             out_valid_q, out_valid_d;
  vector_t          rec_q, rec_d;

  logic             accept, active, is_final;
  logic             push, frame_err_set, xfer;
  logic [FRAME_W-1:0] frame_w;
  vector_t          push_data;
  logic             fifo_full, fifo_empty, fifo_empty_next;
  vector_t          fifo_head_next;
  logic             unused_frame_bits;

  // in_ready follows the registered full flag and is held low during reset.
  assign bus.in_ready = !reset && !fifo_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_final     = (beat_cnt_q == LAST_IDX);

  // The final beat completes the frame straight from in_data, so the vector
  // can be pushed in the same cycle; its low pad bits fall off the slice.
  assign frame_w           = {asm_q, bus.in_data};
  assign push_data         = frame_w[FRAME_W-1 -: COVER_VECTOR_WIDTH];
  assign unused_frame_bits = ^frame_w;

  // Assembler state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CF_UNPK_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Assembler next state: any framing fault returns to beat 0.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      CF_UNPK_IDLE, CF_UNPK_COLLECT: begin
        if (accept) begin
          if (is_final) begin
            beat_cnt_d = '0;
            state_d    = bus.in_last ? CF_UNPK_IDLE : CF_UNPK_DRAIN;
          end else if (bus.in_last) begin
            beat_cnt_d = '0;
            state_d    = CF_UNPK_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = CF_UNPK_COLLECT;
          end
        end
      end
      CF_UNPK_DRAIN: begin
        if (accept && bus.in_last) begin
          state_d = CF_UNPK_IDLE;
        end
      end
      default: begin
        state_d    = CF_UNPK_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Assembler outputs: beat capture, FIFO push and framing-error strobe.
  always_comb begin
    active        = accept && (state_q != CF_UNPK_DRAIN);
    push          = active && is_final && bus.in_last;
    frame_err_set = active && (is_final != bus.in_last);
    asm_d         = asm_q;
    for (int k = 0; k < int'(NUM_BEATS) - 1; k++) begin
      if (active && (beat_cnt_q == CNT_W'(k))) begin
        asm_d[ASM_W - 1 - k * BEAT_W -: BEAT_W] = bus.in_data;
      end
    end
  end

  coverfloat_vec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wdata      (push_data),
    .pop        (xfer),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next),
    .head_next  (fifo_head_next)
  );

  // Output view mirrors the FIFO head; counters and sticky flags.
  always_comb begin
    xfer           = out_valid_q && bus.out_ready;
    out_valid_d    = !fifo_empty_next;
    rec_d          = fifo_head_next;
    frame_err_d    = frame_err_q | frame_err_set;
    vector_count_d = vector_count_q;
    if (xfer) begin
      vector_count_d = vector_count_q + 32'd1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q          <= '0;
      frame_err_q    <= 1'b0;
      vector_count_q <= '0;
      out_valid_q    <= 1'b0;
      rec_q          <= '0;
    end else begin
      asm_q          <= asm_d;
      frame_err_q    <= frame_err_d;
      vector_count_q <= vector_count_d;
      out_valid_q    <= out_valid_d;
      rec_q          <= rec_d;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.out_op             = rec_q.op;
  assign bus.out_rm             = rec_q.rm;
  assign bus.out_a              = rec_q.a;
  assign bus.out_b              = rec_q.b;
  assign bus.out_c              = rec_q.c;
  assign bus.out_operand_fmt    = rec_q.operand_fmt;
  assign bus.out_result         = rec_q.result;
  assign bus.out_result_fmt     = rec_q.result_fmt;
  assign bus.out_exception_bits = rec_q.exception_bits;
  assign bus.out_interm_s       = rec_q.interm_s;
  assign bus.out_interm_x       = rec_q.interm_x;
  assign bus.out_interm_m       = rec_q.interm_m;
  assign bus.vector_count       = vector_count_q;
  assign bus.frame_err          = frame_err_q;

`ifdef COVERFLOAT_UNPACK_CHECK_EN
  logic field_err_seen_q, field_err_seen_d;

  // Sticky flag: some presented record carried non-zero discard bits.
  always_comb begin
    field_err_seen_d = field_err_seen_q | (out_valid_q && (rec_q.discard != '0));
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      field_err_seen_q <= 1'b0;
    end else begin
      field_err_seen_q <= field_err_seen_d;
    end
  end

  assign bus.out_field_err  = out_valid_q && (rec_q.discard != '0);
  assign bus.field_err_seen = field_err_seen_q;
`else
  logic unused_discard;
  assign unused_discard = ^rec_q.discard;
`endif

  logic unused_fifo_empty;
  assign unused_fifo_empty = fifo_empty;

endmodule

// File: tb/tb_coverfloat_vector_unpacker.sv
// Scoreboard bench for coverfloat_vector_unpacker: stimulus pushes expected
// records, a negedge monitor pops and compares on every out transfer.
module tb_coverfloat_vector_unpacker;

  localparam int FRAME_W = 224;
  localparam int BW      = 32;
  localparam int NB      = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coverfloat_vector_unpacker_if #(.BEAT_W(32)) bus ();

  coverfloat_vector_unpacker #(
    .BEAT_W     (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [7:0]  ofmt;
    logic [31:0] res;
    logic [7:0]  rfmt;
    logic [7:0]  exc;
    logic        s;
    logic [7:0]  x;
    logic [31:0] m;
    logic [2:0]  disc;
  } rec_t;

  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          records = 0;
  logic [31:0] model_count = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (timeout) t=%0t", name, $time);
  endtask

  function automatic rec_t mk(input int n, input logic [2:0] disc);
    rec_t r;
    r.op   = 8'h40 + 8'(n);
    r.rm   = 8'(n & 7);
    r.a    = 32'h3F80_0000 + 32'(n);
    r.b    = 32'hC000_0000 | 32'(n);
    r.c    = 32'h1234_5600 + 32'(n);
    r.ofmt = 8'h01;
    r.res  = 32'hDEAD_0000 + 32'(n);
    r.rfmt = 8'h02;
    r.exc  = 8'(1 << (n % 5));
    r.s    = n[0];
    r.x    = 8'h80 + 8'(n);
    r.m    = 32'hA5A5_0000 + 32'(n << 4);
    r.disc = disc;
    return r;
  endfunction

  // Stream layout: fields MSB first, then 12 pad bits (junk, must be ignored).
  function automatic logic [FRAME_W-1:0] pack(input rec_t r);
    return {r.op, r.rm, r.a, r.b, r.c, r.ofmt, r.res, r.rfmt, r.exc,
            r.s, r.x, r.m, r.disc, 12'hABC};
  endfunction

  // Called at posedge+1; sends nbeats beats, in_last on beat last_at (-1: never).
  task automatic send_frame(input logic [FRAME_W-1:0] frame, input int nbeats, input int last_at);
    int budget;
    for (int k = 0; k < nbeats; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = frame[FRAME_W - 1 - k * BW -: BW];
      bus.in_last  = (k == last_at);
      budget = 2000;
      while (!bus.in_ready && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      if (!bus.in_ready) begin
        fail_now("in_ready_wait");
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send_vec(input rec_t r);
    exp_q.push_back(r);
    send_frame(pack(r), NB, NB - 1);
  endtask

  task automatic wait_drain();
    int budget = 500;
    while ((exp_q.size() != 0 || bus.out_valid) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (exp_q.size() != 0 || bus.out_valid) fail_now("drain");
  endtask

  // One-cycle reset; checks the reset-state outputs while reset is applied.
  task automatic apply_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp_q.delete();
    model_count = 32'd0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_a", bus.out_a, 32'd0);
    check("rst_vector_count", bus.vector_count, 32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
`ifdef COVERFLOAT_UNPACK_CHECK_EN
    check("rst_field_err_seen", {31'd0, bus.field_err_seen}, 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Monitor: compare every record at its transfer.
  always @(negedge clk) begin
    rec_t r;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_record");
      end else begin
        r = exp_q.pop_front();
        check("op", {24'd0, bus.out_op}, {24'd0, r.op});
        check("rm", {24'd0, bus.out_rm}, {24'd0, r.rm});
        check("a", bus.out_a, r.a);
        check("b", bus.out_b, r.b);
        check("c", bus.out_c, r.c);
        check("operand_fmt", {24'd0, bus.out_operand_fmt}, {24'd0, r.ofmt});
        check("result", bus.out_result, r.res);
        check("result_fmt", {24'd0, bus.out_result_fmt}, {24'd0, r.rfmt});
        check("exception_bits", {24'd0, bus.out_exception_bits}, {24'd0, r.exc});
        check("interm_s", {31'd0, bus.out_interm_s}, {31'd0, r.s});
        check("interm_x", {24'd0, bus.out_interm_x}, {24'd0, r.x});
        check("interm_m", bus.out_interm_m, r.m);
        check("count_at_xfer", bus.vector_count, model_count);
`ifdef COVERFLOAT_UNPACK_CHECK_EN
        check("out_field_err", {31'd0, bus.out_field_err}, {31'd0, (r.disc != 3'd0)});
`endif
        records++;
        model_count = model_count + 32'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    apply_reset();

    // 1: three back-to-back vectors with a free consumer.
    bus.out_ready = 1'b1;
    send_vec(mk(1, 3'd0));
    send_vec(mk(2, 3'd0));
    send_vec(mk(3, 3'd0));
    wait_drain();
    check("t1_vector_count", bus.vector_count, 32'd3);
    check("t1_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("t1_records", records, 3);

    // 3: early in_last on the third beat, then a good vector.
    send_frame(pack(mk(4, 3'd0)), 3, 2);
    send_vec(mk(5, 3'd0));
    wait_drain();
    check("t3_frame_err", {31'd0, bus.frame_err}, 32'd1);
    check("t3_records", records, 4);
    // missing in_last on the final beat, trailing junk up to in_last, then a good vector
    send_frame(pack(mk(6, 3'd0)), NB, -1);
    send_frame(pack(mk(99, 3'd0)), 2, 1);
    send_vec(mk(7, 3'd0));
    wait_drain();
    check("t3_drain_records", records, 5);
    check("t3_vector_count", bus.vector_count, 32'd5);

    // 4: reset with one vector buffered and another half-assembled.
    bus.out_ready = 1'b0;
    send_vec(mk(8, 3'd0));
    send_frame(pack(mk(9, 3'd0)), 5, -1);
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_record", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    send_vec(mk(20, 3'd0));
    wait_drain();
    check("t4_vector_count", bus.vector_count, 32'd1);

    // 2: back-pressure; FIFO_DEPTH vectors fill, the fifth waits.
    bus.out_ready = 1'b0;
    send_vec(mk(10, 3'd0));
    check("t2_latency_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t2_latency_op", {24'd0, bus.out_op}, 32'h4A);
    send_vec(mk(11, 3'd0));
    send_vec(mk(12, 3'd0));
    send_vec(mk(13, 3'd0));
    check("t2_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_hold_a", bus.out_a, 32'h3F80_000A);
    check("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    send_vec(mk(14, 3'd0));
    wait_drain();
    check("t2_vector_count", bus.vector_count, 32'd6);

    // 5: counter wrap from all-ones.
    bus.out_ready = 1'b0;
    @(negedge clk);
    force dut.vector_count_q = 32'hFFFF_FFFF;
    model_count = 32'hFFFF_FFFF;
    #1;
    release dut.vector_count_q;
    @(posedge clk); #1;
    check("t5_preload", bus.vector_count, 32'hFFFF_FFFF);
    bus.out_ready = 1'b1;
    send_vec(mk(15, 3'd0));
    wait_drain();
    check("t5_wrap", bus.vector_count, 32'd0);

    // 6: non-zero discard bits, then a clean vector.
    send_vec(mk(16, 3'b101));
    send_vec(mk(17, 3'd0));
    wait_drain();
`ifdef COVERFLOAT_UNPACK_CHECK_EN
    check("t6_field_err_seen", {31'd0, bus.field_err_seen}, 32'd1);
`endif
    check("t6_vector_count", bus.vector_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
